// File: rtl/half_subtractor_if.sv
// half_subtractor_if: operand/result bundle for half_subtractor; borr_cnt exists only with HALF_SUB_CNT_EN
interface half_subtractor_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] a, b, diff, borr, diff_q, borr_q;
  logic in_valid, out_valid, any_borr_q;
`ifdef HALF_SUB_CNT_EN
  logic [CNT_W-1:0] borr_cnt;
  modport master(output a, b, in_valid, input diff, borr, diff_q, borr_q, out_valid, any_borr_q, borr_cnt);
  modport slave(input a, b, in_valid, output diff, borr, diff_q, borr_q, out_valid, any_borr_q, borr_cnt);
`else
  modport master(output a, b, in_valid, input diff, borr, diff_q, borr_q, out_valid, any_borr_q);
  modport slave(input a, b, in_valid, output diff, borr, diff_q, borr_q, out_valid, any_borr_q);
`endif
endinterface

// File: rtl/half_subtractor.sv
// half_subtractor: per-lane a-b difference/borrow, combinational plus 1-cycle registered copy; HALF_SUB_CNT_EN adds a saturating borrow counter
module half_subtractor #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  half_subtractor_if.slave bus
);
  logic [WIDTH-1:0] diff, borr, diff_d, diff_q, borr_d, borr_q;
  logic out_valid_d, out_valid_q;
  assign diff = bus.a ^ bus.b;
  assign borr = ~bus.a & bus.b;
  assign bus.diff = diff;
  assign bus.borr = borr;
  assign bus.diff_q = diff_q;
  assign bus.borr_q = borr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.any_borr_q = |borr_q;
  // reset clears, valid captures, otherwise data holds and valid drops
  always_comb begin
    diff_d = rst ? '0 : bus.in_valid ? diff : diff_q;
    borr_d = rst ? '0 : bus.in_valid ? borr : borr_q;
    out_valid_d = !rst && bus.in_valid;
  end
  // result register
  always_ff @(posedge clk) begin
    diff_q <= diff_d;
    borr_q <= borr_d;
    out_valid_q <= out_valid_d;
  end
`ifdef HALF_SUB_CNT_EN
  localparam int SW = CNT_W + $clog2(WIDTH + 1) + 1;
  localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});
  logic [SW-1:0] pop, sum;
  logic [CNT_W-1:0] borr_cnt_d, borr_cnt_q;
  assign bus.borr_cnt = borr_cnt_q;
  // add this cycle's borrow popcount, clamping at all-ones instead of wrapping
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + SW'(borr[i]);
    sum = SW'(borr_cnt_q) + pop;
    borr_cnt_d = rst ? '0 : !bus.in_valid ? borr_cnt_q : sum > CNT_MAX ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end
  // borrow event counter register
  always_ff @(posedge clk) borr_cnt_q <= borr_cnt_d;
`endif
endmodule

// File: tb/tb_half_subtractor.sv
// tb_half_subtractor: random and directed checks of a 1-lane and a 4-lane half_subtractor against an arithmetic model
module tb_half_subtractor;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0, rst = 1;
  int checks = 0, errors = 0;
  logic [3:0] m4_dq, m4_bq;
  logic m1_dq, m1_bq, m_ov;
  int m_cnt;
  half_subtractor_if #(.WIDTH(1)) if1();
  half_subtractor_if #(.WIDTH(4), .CNT_W(CW)) if4();
  half_subtractor #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  half_subtractor #(.WIDTH(4), .CNT_W(CW)) u4 (.clk(clk), .rst(rst), .bus(if4));
  always #5 clk = ~clk;
  function automatic logic [3:0] m_diff(logic [3:0] a, logic [3:0] b);
    logic [3:0] d;
    for (int i = 0; i < 4; i++) d[i] = ((int'(a[i]) - int'(b[i])) % 2) != 0;
    return d;
  endfunction
  function automatic logic [3:0] m_borr(logic [3:0] a, logic [3:0] b);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = int'(a[i]) < int'(b[i]);
    return r;
  endfunction
  function automatic int popc(logic [3:0] x);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(x[i]);
    return n;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_comb();
    chk("diff4", 32'(if4.diff), 32'(m_diff(if4.a, if4.b)));
    chk("borr4", 32'(if4.borr), 32'(m_borr(if4.a, if4.b)));
    chk("diff1", 32'(if1.diff), 32'(m_diff({3'b0, if1.a}, {3'b0, if1.b})));
    chk("borr1", 32'(if1.borr), 32'(m_borr({3'b0, if1.a}, {3'b0, if1.b})));
  endtask
  task automatic chk_regs();
    chk("diff_q4", 32'(if4.diff_q), 32'(m4_dq));
    chk("borr_q4", 32'(if4.borr_q), 32'(m4_bq));
    chk("any4", 32'(if4.any_borr_q), 32'(m4_bq != 0));
    chk("valid4", 32'(if4.out_valid), 32'(m_ov));
    chk("diff_q1", 32'(if1.diff_q), 32'(m1_dq));
    chk("borr_q1", 32'(if1.borr_q), 32'(m1_bq));
    chk("any1", 32'(if1.any_borr_q), 32'(m1_bq));
    chk("valid1", 32'(if1.out_valid), 32'(m_ov));
`ifdef HALF_SUB_CNT_EN
    chk("cnt4", 32'(if4.borr_cnt), 32'(m_cnt));
`endif
  endtask
  task automatic step(logic [3:0] a4, logic [3:0] b4, logic a1, logic b1, logic v, logic r);
    logic [3:0] d4, br4, d1, br1;
    @(negedge clk);
    if4.a = a4; if4.b = b4; if1.a = a1; if1.b = b1; if4.in_valid = v; if1.in_valid = v; rst = r;
    #1 chk_comb();
    d4 = m_diff(a4, b4); br4 = m_borr(a4, b4);
    d1 = m_diff({3'b0, a1}, {3'b0, b1}); br1 = m_borr({3'b0, a1}, {3'b0, b1});
    @(posedge clk);
    if (r) begin
      m4_dq = 0; m4_bq = 0; m1_dq = 0; m1_bq = 0; m_cnt = 0;
    end else if (v) begin
      m4_dq = d4; m4_bq = br4; m1_dq = d1[0]; m1_bq = br1[0];
      m_cnt = (m_cnt + popc(br4) > CMAX) ? CMAX : m_cnt + popc(br4);
    end
    m_ov = !r && v;
    #1 chk_regs();
  endtask
  initial begin
    if4.a = 0; if4.b = 0; if4.in_valid = 0; if1.a = 0; if1.b = 0; if1.in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      {if1.a, if1.b} = 2'(i);
      #5 chk("sweep_diff", 32'(if1.diff), 32'(i == 1 || i == 2));
      chk("sweep_borr", 32'(if1.borr), 32'(i == 1));
    end
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_valid", 32'(if1.out_valid), 0);
    chk("rst_any", 32'(if4.any_borr_q), 0);
    step(4'h1, 4'hE, 0, 1, 1, 0);
    chk("dir_dq1", 32'(if1.diff_q), 1);
    chk("dir_bq1", 32'(if1.borr_q), 1);
    chk("dir_any1", 32'(if1.any_borr_q), 1);
    step(4'h3, 4'h3, 1, 1, 0, 0);
    chk("hold_valid", 32'(if1.out_valid), 0);
    chk("hold_bq1", 32'(if1.borr_q), 1);
    @(negedge clk);
    if1.a = 0; if1.b = 1; if1.in_valid = 1; if4.in_valid = 1; rst = 1;
    #1 chk("rstpri_diff", 32'(if1.diff), 1);
    chk("rstpri_borr", 32'(if1.borr), 1);
    @(posedge clk); #1;
    chk("rstpri_dq", 32'(if1.diff_q), 0);
    chk("rstpri_bq", 32'(if1.borr_q), 0);
    chk("rstpri_valid", 32'(if1.out_valid), 0);
    m4_dq = 0; m4_bq = 0; m1_dq = 0; m1_bq = 0; m_ov = 0; m_cnt = 0;
    step(4'b0101, 4'b0011, 0, 0, 1, 0);
    chk("w4_dq", 32'(if4.diff_q), 32'b0110);
    chk("w4_bq", 32'(if4.borr_q), 32'b0010);
`ifdef HALF_SUB_CNT_EN
    step(0, 0, 0, 0, 0, 1);
    step(0, 4'hF, 0, 0, 1, 0);
    chk("cnt_a", 32'(if4.borr_cnt), 4);
    step(0, 4'hF, 0, 0, 1, 0);
    chk("cnt_b", 32'(if4.borr_cnt), 7);
    step(0, 4'hF, 0, 0, 1, 0);
    chk("cnt_sat", 32'(if4.borr_cnt), 7);
    step(0, 4'hF, 0, 0, 1, 1);
    chk("cnt_rst", 32'(if4.borr_cnt), 0);
`endif
    for (int n = 0; n < 300; n++)
      step(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 19) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
